// File: rtl/trace_buffer_mc_pkg.sv
// trace_pkg: shared types and constants for the multi-channel trace buffer.
//   overflow_mode_e        - what a full channel does with an unpoppable push
//   trace_entry_t          - one stored element at the default widths
//   DEFAULT_*              - default widths used by the interface and top
package trace_pkg;

    typedef enum logic {
        DROP_NEW      = 1'b0,  // keep stored elements, discard the incoming one
        OVERWRITE_OLD = 1'b1   // keep the incoming element, discard the oldest
    } overflow_mode_e;

    localparam int DEFAULT_TRACE_WIDTH    = 64;
    localparam int DEFAULT_STAMP_WIDTH    = 32;
    localparam int DEFAULT_DROP_CNT_WIDTH = 16;

    typedef struct packed {
        logic [DEFAULT_TRACE_WIDTH-1:0] data;
        logic [DEFAULT_STAMP_WIDTH-1:0] stamp;
    } trace_entry_t;

endpackage

// File: rtl/trace_buffer_mc_if.sv
// trace_buffer_mc_if: producer/consumer bundle of the multi-channel trace buffer.
//   in_valid/in_data/in_stamp  - per-channel push strobes and payloads (ch0 in LSBs)
//   out_ready                  - consumer accepts the output register this cycle
//   out_valid/out_data/out_stamp/out_channel - registered output element
//   data_present/occupancy/almost_full/drop_count - registered status
// master: the side that produces trace and consumes output; slave: the buffer.
interface trace_buffer_mc_if #(
    parameter int CHANNELS       = 2,
    parameter int DEPTH          = 8,
    parameter int TRACE_WIDTH    = trace_pkg::DEFAULT_TRACE_WIDTH,
    parameter int STAMP_WIDTH    = trace_pkg::DEFAULT_STAMP_WIDTH,
    parameter int DROP_CNT_WIDTH = trace_pkg::DEFAULT_DROP_CNT_WIDTH
);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic [CHANNELS-1:0]                     in_valid;
    logic [CHANNELS-1:0][TRACE_WIDTH-1:0]    in_data;
    logic [CHANNELS-1:0][STAMP_WIDTH-1:0]    in_stamp;
    logic                                    out_ready;
    logic                                    out_valid;
    logic [TRACE_WIDTH-1:0]                  out_data;
    logic [STAMP_WIDTH-1:0]                  out_stamp;
    logic [CH_W-1:0]                         out_channel;
    logic                                    data_present;
    logic [CHANNELS-1:0][OCC_W-1:0]          occupancy;
    logic [CHANNELS-1:0]                     almost_full;
    logic [CHANNELS-1:0][DROP_CNT_WIDTH-1:0] drop_count;

    modport master (
        output in_valid, in_data, in_stamp, out_ready,
        input  out_valid, out_data, out_stamp, out_channel,
        input  data_present, occupancy, almost_full, drop_count
    );

    modport slave (
        input  in_valid, in_data, in_stamp, out_ready,
        output out_valid, out_data, out_stamp, out_channel,
        output data_present, occupancy, almost_full, drop_count
    );

endinterface

// File: rtl/trace_buffer_mc_fifo_ch.sv
// trace_fifo_ch: one channel's circular FIFO with overflow policy and drop counter.
//   clk, rst       - clock, synchronous active-high reset
//   push/push_data - element to store this edge (no backpressure)
//   pop            - remove the head this edge (never asserted when empty)
//   head           - element at the read pointer
//   empty          - no stored elements (from the registered count)
//   occupancy      - registered entry count
//   almost_full    - registered, occupancy >= ALMOST_FULL_LVL
//   nonempty_next  - combinational: channel will hold data after this edge
//   drop_count     - saturating count of elements lost to overflow
module trace_fifo_ch
    import trace_pkg::*;
#(
    parameter int             DEPTH           = 8,
    parameter int             WIDTH           = 96,
    parameter int             ALMOST_FULL_LVL = DEPTH - 2,
    parameter int             DROP_CNT_WIDTH  = DEFAULT_DROP_CNT_WIDTH,
    parameter overflow_mode_e OVERFLOW_MODE   = DROP_NEW
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    output logic [WIDTH-1:0]          head,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic                      almost_full,
    output logic                      nonempty_next,
    output logic [DROP_CNT_WIDTH-1:0] drop_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [PTR_W-1:0]          wr_ptr, rd_ptr;
    logic [OCC_W-1:0]          count, count_next;
    logic [DROP_CNT_WIDTH-1:0] drops;
    logic                      af_q;
    logic                      full, overflow, do_write, rd_adv;

    always_comb begin
        full       = (count == OCC_W'(DEPTH));
        // A pop in the same edge frees a slot, so only push-without-pop overflows.
        overflow   = push && full && !pop;
        do_write   = push && (!overflow || (OVERFLOW_MODE == OVERWRITE_OLD));
        // Overwrite discards the oldest element by stepping the read pointer.
        rd_adv     = pop || (overflow && (OVERFLOW_MODE == OVERWRITE_OLD));
        count_next = count + OCC_W'(do_write) - OCC_W'(rd_adv);
    end

    // Storage is not reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            drops  <= '0;
            af_q   <= 1'b0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_adv)   rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
            af_q  <= (count_next >= OCC_W'(ALMOST_FULL_LVL));
            if (overflow && (drops != '1)) drops <= drops + DROP_CNT_WIDTH'(1);
        end
    end

    assign head          = mem[rd_ptr];
    assign empty         = (count == '0);
    assign occupancy     = count;
    assign almost_full   = af_q;
    assign nonempty_next = (count_next != '0);
    assign drop_count    = drops;

endmodule

// File: rtl/trace_buffer_mc.sv
// trace_buffer_mc: CHANNELS independent trace FIFOs merged by a round-robin
// arbiter into one registered valid/ready output.
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - trace_buffer_mc_if.slave: per-channel pushes in, merged stream and
//          per-channel status (occupancy, almost_full, drop_count) out
module trace_buffer_mc
    import trace_pkg::*;
#(
    parameter int             CHANNELS        = 2,
    parameter int             DEPTH           = 8,
    parameter int             TRACE_WIDTH     = DEFAULT_TRACE_WIDTH,
    parameter int             STAMP_WIDTH     = DEFAULT_STAMP_WIDTH,
    parameter overflow_mode_e OVERFLOW_MODE   = DROP_NEW,
    parameter int             ALMOST_FULL_LVL = DEPTH - 2,
    parameter int             DROP_CNT_WIDTH  = DEFAULT_DROP_CNT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    trace_buffer_mc_if.slave   bus
);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = TRACE_WIDTH + STAMP_WIDTH;

    logic [CHANNELS-1:0]                     empty, pop, nonempty_next, af;
    logic [CHANNELS-1:0][ENT_W-1:0]          head;
    logic [CHANNELS-1:0][OCC_W-1:0]          occ;
    logic [CHANNELS-1:0][DROP_CNT_WIDTH-1:0] drops;

    // Entries are stored as {stamp, data}.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        trace_fifo_ch #(
            .DEPTH           (DEPTH),
            .WIDTH           (ENT_W),
            .ALMOST_FULL_LVL (ALMOST_FULL_LVL),
            .DROP_CNT_WIDTH  (DROP_CNT_WIDTH),
            .OVERFLOW_MODE   (OVERFLOW_MODE)
        ) u_fifo (
            .clk           (clk),
            .rst           (rst),
            .push          (bus.in_valid[g]),
            .push_data     ({bus.in_stamp[g], bus.in_data[g]}),
            .pop           (pop[g]),
            .head          (head[g]),
            .empty         (empty[g]),
            .occupancy     (occ[g]),
            .almost_full   (af[g]),
            .nonempty_next (nonempty_next[g]),
            .drop_count    (drops[g])
        );
    end

    logic                   out_valid_q, data_present_q;
    logic [TRACE_WIDTH-1:0] out_data_q;
    logic [STAMP_WIDTH-1:0] out_stamp_q;
    logic [CH_W-1:0]        out_channel_q;
    // rr_ptr is the first channel searched, i.e. one past the last grant.
    logic [CH_W-1:0]        rr_ptr, rr_next, grant;
    logic                   grant_vld, load, ov_next;
    logic [CH_W:0]          sum;
    logic [ENT_W-1:0]       sel;

    // Round-robin search from rr_ptr upward with wrap; CHANNELS need not be a
    // power of two, so the wrap is an explicit subtract.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        sum       = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sum = {1'b0, rr_ptr} + (CH_W+1)'(i);
            if (sum >= (CH_W+1)'(CHANNELS)) sum = sum - (CH_W+1)'(CHANNELS);
            if (!grant_vld && !empty[sum[CH_W-1:0]]) begin
                grant_vld = 1'b1;
                grant     = sum[CH_W-1:0];
            end
        end
    end

    // The output register is a bubble-free stage: it reloads whenever it is
    // empty or being consumed this edge.
    always_comb begin
        load    = !out_valid_q || bus.out_ready;
        ov_next = load ? grant_vld : out_valid_q;
        rr_next = (grant == CH_W'(CHANNELS - 1)) ? '0 : grant + CH_W'(1);
        sel     = head[grant];
        pop     = '0;
        if (load && grant_vld) pop[grant] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_stamp_q    <= '0;
            out_channel_q  <= '0;
            rr_ptr         <= '0;
            data_present_q <= 1'b0;
        end else begin
            if (load) begin
                out_valid_q <= grant_vld;
                if (grant_vld) begin
                    out_data_q    <= sel[TRACE_WIDTH-1:0];
                    out_stamp_q   <= sel[ENT_W-1:TRACE_WIDTH];
                    out_channel_q <= grant;
                    rr_ptr        <= rr_next;
                end
            end
            data_present_q <= (|nonempty_next) || ov_next;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_stamp    = out_stamp_q;
    assign bus.out_channel  = out_channel_q;
    assign bus.data_present = data_present_q;
    assign bus.occupancy    = occ;
    assign bus.almost_full  = af;
    assign bus.drop_count   = drops;

endmodule

// File: tb/tb_trace_buffer_mc.sv
// Bench for trace_buffer_mc: two instances (DROP_NEW and OVERWRITE_OLD, DEPTH=4,
// 3-bit drop counters) share one stimulus stream. A cycle table covers reset,
// single push latency and round-robin order; hand sequences cover overflow,
// output hold, full push-with-pop, drop saturation and mid-run reset.
// Expected output elements are queued per instance and compared on handshake.
module tb_trace_buffer_mc;
    import trace_pkg::*;

    localparam int CH  = 2;
    localparam int DEP = 4;
    localparam int TW  = 64;
    localparam int SW  = 32;
    localparam int DCW = 3;

    logic clk = 1'b0;
    logic rst;
    logic [CH-1:0]         in_valid;
    logic [CH-1:0][TW-1:0] in_data;
    logic [CH-1:0][SW-1:0] in_stamp;
    logic                  out_ready;

    always #5 clk = ~clk;

    trace_buffer_mc_if #(.CHANNELS(CH), .DEPTH(DEP), .TRACE_WIDTH(TW),
                         .STAMP_WIDTH(SW), .DROP_CNT_WIDTH(DCW)) bus_a ();
    trace_buffer_mc_if #(.CHANNELS(CH), .DEPTH(DEP), .TRACE_WIDTH(TW),
                         .STAMP_WIDTH(SW), .DROP_CNT_WIDTH(DCW)) bus_b ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_data   = in_data;
    assign bus_a.in_stamp  = in_stamp;
    assign bus_a.out_ready = out_ready;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_data   = in_data;
    assign bus_b.in_stamp  = in_stamp;
    assign bus_b.out_ready = out_ready;

    trace_buffer_mc #(.CHANNELS(CH), .DEPTH(DEP), .TRACE_WIDTH(TW), .STAMP_WIDTH(SW),
                      .OVERFLOW_MODE(DROP_NEW), .DROP_CNT_WIDTH(DCW))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    trace_buffer_mc #(.CHANNELS(CH), .DEPTH(DEP), .TRACE_WIDTH(TW), .STAMP_WIDTH(SW),
                      .OVERFLOW_MODE(OVERWRITE_OLD), .DROP_CNT_WIDTH(DCW))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    typedef struct {
        logic [TW-1:0] data;
        logic [SW-1:0] stamp;
        int            ch;
    } exp_t;

    typedef struct {
        logic          rst;
        logic [1:0]    vld;
        logic [TW-1:0] d0, d1;
        logic          rdy;
        logic          ov;
        logic [TW-1:0] od;
        logic          oc;
        logic          dp;
        logic [2:0]    occ0, occ1;
        logic [1:0]    af;
    } vec_t;

    exp_t q_a[$];
    exp_t q_b[$];
    vec_t tbl[10];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [SW-1:0] stamp_of(input logic [TW-1:0] d);
        return d[SW-1:0] ^ 32'hC0DE_5A00;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_ab(input string nm, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp);
        chk({"a_", nm}, a, exp);
        chk({"b_", nm}, b, exp);
    endtask

    // which: 0 = DROP_NEW instance, 1 = OVERWRITE_OLD instance, 2 = both
    task automatic push_exp(input int which, input logic [TW-1:0] d, input int ch);
        exp_t e;
        e.data  = d;
        e.stamp = stamp_of(d);
        e.ch    = ch;
        if (which != 1) q_a.push_back(e);
        if (which != 0) q_b.push_back(e);
    endtask

    task automatic sb_one(input int which, input logic ov, input logic [TW-1:0] d,
                          input logic [SW-1:0] s, input logic c);
        exp_t e;
        if (!ov) return;
        if ((which == 0 && q_a.size() == 0) || (which == 1 && q_b.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL sb%0d_unexpected actual=%0h required=none", which, d);
            return;
        end
        if (which == 0) e = q_a.pop_front();
        else            e = q_b.pop_front();
        chk($sformatf("sb%0d_data", which),  d,        e.data);
        chk($sformatf("sb%0d_stamp", which), 64'(s),   64'(e.stamp));
        chk($sformatf("sb%0d_chan", which),  64'(c),   64'(e.ch));
    endtask

    // Sample handshakes mid-cycle, then advance one edge and settle.
    task automatic cyc();
        @(negedge clk);
        if (!rst && out_ready) begin
            sb_one(0, bus_a.out_valid, bus_a.out_data, bus_a.out_stamp, bus_a.out_channel);
            sb_one(1, bus_b.out_valid, bus_b.out_data, bus_b.out_stamp, bus_b.out_channel);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        out_ready = 1'b1;
        in_valid  = '0;
        while ((bus_a.data_present || bus_b.data_present) && n < 30) begin
            cyc();
            n++;
        end
        chk_ab({nm, "_drained"}, 64'(bus_a.data_present), 64'(bus_b.data_present), 64'd0);
        chk_ab({nm, "_sb_left"}, 64'(q_a.size()), 64'(q_b.size()), 64'd0);
    endtask

    task automatic check_row(input string tag, input vec_t v, input logic ov,
                             input logic [TW-1:0] od, input logic oc, input logic dp,
                             input logic [2:0] o0, input logic [2:0] o1, input logic [1:0] af);
        chk({tag, "_out_valid"}, 64'(ov), 64'(v.ov));
        if (v.ov) begin
            chk({tag, "_out_data"}, od, v.od);
            chk({tag, "_out_chan"}, 64'(oc), 64'(v.oc));
        end
        chk({tag, "_data_present"}, 64'(dp), 64'(v.dp));
        chk({tag, "_occ0"}, 64'(o0), 64'(v.occ0));
        chk({tag, "_occ1"}, 64'(o1), 64'(v.occ1));
        chk({tag, "_almost_full"}, 64'(af), 64'(v.af));
    endtask

    task automatic push_ch(input int ch, input logic [TW-1:0] d);
        in_valid       = '0;
        in_valid[ch]   = 1'b1;
        in_data[ch]    = d;
        in_stamp[ch]   = stamp_of(d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rst   vld    d0       d1       rdy   ov    od       oc    dp    occ0  occ1  af
        tbl[0] = '{1'b0, 2'b01, 64'h11, 64'h0,  1'b1, 1'b0, 64'h0,  1'b0, 1'b1, 3'd1, 3'd0, 2'b00};
        tbl[1] = '{1'b0, 2'b00, 64'h0,  64'h0,  1'b1, 1'b1, 64'h11, 1'b0, 1'b1, 3'd0, 3'd0, 2'b00};
        tbl[2] = '{1'b0, 2'b00, 64'h0,  64'h0,  1'b1, 1'b0, 64'h0,  1'b0, 1'b0, 3'd0, 3'd0, 2'b00};
        tbl[3] = '{1'b1, 2'b00, 64'h0,  64'h0,  1'b1, 1'b0, 64'h0,  1'b0, 1'b0, 3'd0, 3'd0, 2'b00};
        tbl[4] = '{1'b0, 2'b11, 64'hA0, 64'hB0, 1'b1, 1'b0, 64'h0,  1'b0, 1'b1, 3'd1, 3'd1, 2'b00};
        tbl[5] = '{1'b0, 2'b11, 64'hA1, 64'hB1, 1'b1, 1'b1, 64'hA0, 1'b0, 1'b1, 3'd1, 3'd2, 2'b10};
        tbl[6] = '{1'b0, 2'b00, 64'h0,  64'h0,  1'b1, 1'b1, 64'hB0, 1'b1, 1'b1, 3'd1, 3'd1, 2'b00};
        tbl[7] = '{1'b0, 2'b00, 64'h0,  64'h0,  1'b1, 1'b1, 64'hA1, 1'b0, 1'b1, 3'd0, 3'd1, 2'b00};
        tbl[8] = '{1'b0, 2'b00, 64'h0,  64'h0,  1'b1, 1'b1, 64'hB1, 1'b1, 1'b1, 3'd0, 3'd0, 2'b00};
        tbl[9] = '{1'b0, 2'b00, 64'h0,  64'h0,  1'b1, 1'b0, 64'h0,  1'b0, 1'b0, 3'd0, 3'd0, 2'b00};

        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        in_stamp  = '0;
        out_ready = 1'b0;
        cyc();
        cyc();
        chk_ab("rst_out_valid", 64'(bus_a.out_valid), 64'(bus_b.out_valid), 64'd0);
        chk_ab("rst_out_data", bus_a.out_data, bus_b.out_data, 64'd0);
        chk_ab("rst_data_present", 64'(bus_a.data_present), 64'(bus_b.data_present), 64'd0);
        chk_ab("rst_occupancy", 64'(bus_a.occupancy), 64'(bus_b.occupancy), 64'd0);
        chk_ab("rst_almost_full", 64'(bus_a.almost_full), 64'(bus_b.almost_full), 64'd0);
        chk_ab("rst_drop_count", 64'(bus_a.drop_count), 64'(bus_b.drop_count), 64'd0);
        rst = 1'b0;

        // Single-push latency, then reset and round-robin order A0,B0,A1,B1.
        for (int r = 0; r < 10; r++) begin
            rst         = tbl[r].rst;
            in_valid    = tbl[r].vld;
            in_data[0]  = tbl[r].d0;
            in_data[1]  = tbl[r].d1;
            in_stamp[0] = stamp_of(tbl[r].d0);
            in_stamp[1] = stamp_of(tbl[r].d1);
            out_ready   = tbl[r].rdy;
            if (tbl[r].rst) begin
                q_a.delete();
                q_b.delete();
            end else begin
                if (tbl[r].vld[0]) push_exp(2, tbl[r].d0, 0);
                if (tbl[r].vld[1]) push_exp(2, tbl[r].d1, 1);
            end
            cyc();
            check_row($sformatf("a_row%0d", r), tbl[r], bus_a.out_valid, bus_a.out_data,
                      bus_a.out_channel, bus_a.data_present, bus_a.occupancy[0],
                      bus_a.occupancy[1], bus_a.almost_full);
            check_row($sformatf("b_row%0d", r), tbl[r], bus_b.out_valid, bus_b.out_data,
                      bus_b.out_channel, bus_b.data_present, bus_b.occupancy[0],
                      bus_b.occupancy[1], bus_b.almost_full);
        end
        rst = 1'b0;
        chk_ab("table_sb_left", 64'(q_a.size()), 64'(q_b.size()), 64'd0);

        // Overflow of ch1 with the consumer stalled: 1 sits in the output
        // register, DROP_NEW keeps 2..5, OVERWRITE_OLD keeps 3..6.
        rst = 1'b1;
        in_valid = '0;
        cyc();
        rst = 1'b0;
        out_ready = 1'b0;
        for (int v = 1; v <= 5; v++) push_exp(0, 64'(v), 1);
        push_exp(1, 64'd1, 1);
        for (int v = 3; v <= 6; v++) push_exp(1, 64'(v), 1);
        for (int v = 1; v <= 6; v++) begin
            push_ch(1, 64'(v));
            cyc();
        end
        in_valid = '0;
        chk_ab("ovf_occ1", 64'(bus_a.occupancy[1]), 64'(bus_b.occupancy[1]), 64'd4);
        chk_ab("ovf_drop1", 64'(bus_a.drop_count[1]), 64'(bus_b.drop_count[1]), 64'd1);
        chk_ab("ovf_af1", 64'(bus_a.almost_full[1]), 64'(bus_b.almost_full[1]), 64'd1);
        chk_ab("ovf_out_data", bus_a.out_data, bus_b.out_data, 64'd1);

        // Stalled output must hold its element and not pop.
        for (int h = 0; h < 5; h++) begin
            cyc();
            chk_ab("hold_valid", 64'(bus_a.out_valid), 64'(bus_b.out_valid), 64'd1);
            chk_ab("hold_data", bus_a.out_data, bus_b.out_data, 64'd1);
            chk_ab("hold_stamp", 64'(bus_a.out_stamp), 64'(bus_b.out_stamp), 64'(stamp_of(64'd1)));
            chk_ab("hold_chan", 64'(bus_a.out_channel), 64'(bus_b.out_channel), 64'd1);
            chk_ab("hold_occ1", 64'(bus_a.occupancy[1]), 64'(bus_b.occupancy[1]), 64'd4);
        end

        // Push into a full channel on the same edge it pops: no drop.
        out_ready = 1'b1;
        push_ch(1, 64'd7);
        push_exp(2, 64'd7, 1);
        cyc();
        in_valid = '0;
        chk_ab("fullpop_occ1", 64'(bus_a.occupancy[1]), 64'(bus_b.occupancy[1]), 64'd4);
        chk_ab("fullpop_drop1", 64'(bus_a.drop_count[1]), 64'(bus_b.drop_count[1]), 64'd1);
        drain("ovf");

        // Drop counter saturation on ch0: 9 overflowing pushes, 3-bit counter.
        out_ready = 1'b0;
        for (int v = 1; v <= 5; v++) push_exp(0, 64'h100 + 64'(v), 0);
        push_exp(1, 64'h101, 0);
        for (int v = 11; v <= 14; v++) push_exp(1, 64'h100 + 64'(v), 0);
        for (int v = 1; v <= 14; v++) begin
            push_ch(0, 64'h100 + 64'(v));
            cyc();
        end
        in_valid = '0;
        chk_ab("sat_drop0", 64'(bus_a.drop_count[0]), 64'(bus_b.drop_count[0]), 64'd7);
        chk_ab("sat_drop1", 64'(bus_a.drop_count[1]), 64'(bus_b.drop_count[1]), 64'd1);
        drain("sat");

        // Reset with ch0 holding 3 entries and a valid output element.
        out_ready = 1'b0;
        for (int v = 1; v <= 4; v++) begin
            push_exp(2, 64'h200 + 64'(v), 0);
            push_ch(0, 64'h200 + 64'(v));
            cyc();
        end
        in_valid = '0;
        chk_ab("pre_rst_occ0", 64'(bus_a.occupancy[0]), 64'(bus_b.occupancy[0]), 64'd3);
        chk_ab("pre_rst_valid", 64'(bus_a.out_valid), 64'(bus_b.out_valid), 64'd1);
        rst = 1'b1;
        out_ready = 1'b1;
        q_a.delete();
        q_b.delete();
        cyc();
        rst = 1'b0;
        chk_ab("mid_rst_valid", 64'(bus_a.out_valid), 64'(bus_b.out_valid), 64'd0);
        chk_ab("mid_rst_occ", 64'(bus_a.occupancy), 64'(bus_b.occupancy), 64'd0);
        chk_ab("mid_rst_drop", 64'(bus_a.drop_count), 64'(bus_b.drop_count), 64'd0);
        chk_ab("mid_rst_dp", 64'(bus_a.data_present), 64'(bus_b.data_present), 64'd0);
        push_ch(0, 64'h55);
        push_exp(2, 64'h55, 0);
        cyc();
        in_valid = '0;
        chk_ab("post_rst_k_valid", 64'(bus_a.out_valid), 64'(bus_b.out_valid), 64'd0);
        cyc();
        chk_ab("post_rst_k1_valid", 64'(bus_a.out_valid), 64'(bus_b.out_valid), 64'd1);
        chk_ab("post_rst_k1_data", bus_a.out_data, bus_b.out_data, 64'h55);
        drain("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trace_buffer_mc.md
Name: trace_buffer_mc

Overview:
- Multi-channel successor to the single-stream trace buffer.
- Accepts trace elements plus their decode-stage-end stamp from CHANNELS independent producers, one per-channel circular FIFO each.
- Round-robin arbitration feeds a single registered output with a valid/ready handshake toward the trace consumer.
- Adds a selectable overflow policy, per-channel drop counters, occupancy and almost-full flags; the single-stream block has none of these.

Parameters:
- CHANNELS, 2, number of independent input channels (1..8).
- DEPTH, 8, entries per channel FIFO; power of two, at least 2.
- TRACE_WIDTH, 64, bits per trace element.
- STAMP_WIDTH, 32, bits of decode-stage-end stamp carried with each element.
- OVERFLOW_MODE, DROP_NEW, trace_pkg::overflow_mode_e. DROP_NEW discards the incoming element; OVERWRITE_OLD discards the oldest stored element.
- ALMOST_FULL_LVL, DEPTH-2, occupancy at or above which almost_full asserts.
- DROP_CNT_WIDTH, 16, width of each saturating drop counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  CHANNELS  per-channel push strobe. No backpressure: sampled every cycle.
- in_data  in  CHANNELS*TRACE_WIDTH  packed elements, channel 0 in LSBs.
- in_stamp  in  CHANNELS*STAMP_WIDTH  packed stamps, channel 0 in LSBs.
- out_ready  in  1  consumer accepts output this cycle.
- out_valid  out  1  output registers hold a valid element.
- out_data  out  TRACE_WIDTH  element.
- out_stamp  out  STAMP_WIDTH  stamp.
- out_channel  out  $clog2(CHANNELS) (min 1)  source channel of the element.
- data_present  out  1  any FIFO non-empty or out_valid.
- occupancy  out  CHANNELS*($clog2(DEPTH)+1)  per-channel entry count.
- almost_full  out  CHANNELS  occupancy >= ALMOST_FULL_LVL.
- drop_count  out  CHANNELS*DROP_CNT_WIDTH  per-channel saturating drop counter.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high. The polarity and synchronicity are fixed.
- Reset: all outputs are 0, all pointers and counts are 0, the arbiter pointer is 0, and FIFO contents are discarded.
- Reset mid-operation: FIFO contents and the output register are discarded. out_valid is 0 after the reset edge, whatever the state of out_ready.
- Push: at an edge with in_valid[c]=1, the element is written at the channel's wr_ptr and wr_ptr advances modulo DEPTH.
- Output register load: loads when !out_valid || out_ready, a pipeline stage with no bubble.
  - On load, the arbiter pops one element from the granted channel and out_valid becomes 1.
  - If no channel is non-empty, out_valid becomes 0 when out_ready=1, and holds otherwise.
- Handshake: out_data, out_stamp and out_channel stay stable while out_valid && !out_ready.
- Latency: an element pushed into an empty buffer at edge k appears with out_valid=1 after edge k+1. Sustained throughput is one element per cycle.
- Arbiter (round-robin):
  - Searches from last_grant+1 upward, with wrap, among non-empty channels.
  - last_grant updates only on an actual pop.
  - A push and a pop of the same channel in the same cycle are both performed; the newly pushed element is not poppable that cycle.
- Full channel, push without pop:
  - DROP_NEW: the incoming element is discarded and drop_count[c] increments.
  - OVERWRITE_OLD: the element is written, rd_ptr advances (the oldest is lost), occupancy stays DEPTH, and drop_count[c] increments.
- Full channel, push with simultaneous pop: no drop in either mode; occupancy stays DEPTH.
- Pop from an empty channel never happens.
- drop_count saturates at all-ones and clears only on rst.
- occupancy, almost_full and data_present are registered and reflect state after the edge.

Decomposition:
- trace_pkg holds:
  - the overflow_mode_e enum {DROP_NEW, OVERWRITE_OLD};
  - a trace_entry_t struct {data, stamp};
  - a DEFAULT_DROP_CNT_WIDTH constant.
- One sub-module, trace_fifo_ch, is instantiated CHANNELS times via generate. It is a single-channel circular FIFO with:
  - push/pop inputs;
  - full/empty/occupancy outputs;
  - the overflow policy and drop counter.
- Arbiter and output register stay in the top level.

Test Plan:
- Reset then push ch0 data=0x11 at edge 1 (out_ready=1) → out_valid=1, out_data=0x11, out_channel=0 after edge 2; data_present=0 after edge 3.
- CHANNELS=2: push ch0 {A0,A1} and ch1 {B0,B1} simultaneously on two edges, out_ready=1 → output order A0,B0,A1,B1.
- DROP_NEW, DEPTH=4, out_ready=0: push 6 elements 1..6 to ch1. The output register takes 1, so ch1 holds 2..5, occupancy=4, drop_count[1]=1. Then raise out_ready → outputs 1,2,3,4,5.
- Same scenario with OVERWRITE_OLD → ch1 holds 3..6, drop_count[1]=1, and the outputs are 1,3,4,5,6.
- Hold out_ready=0 for 5 cycles with out_valid=1 → out_data, out_stamp and out_channel unchanged; no pop and no occupancy change.
- Assert rst for one cycle while ch0 has occupancy 3 and out_valid=1 → after the edge out_valid=0, occupancy=0 and drop_count=0. A push at the next edge appears two edges later.
